// File: rtl/frame_buffer_sched.sv
// frame_buffer_sched: double-buffered frame capture scheduler that writes into one bank while the display reads the other
module frame_buffer_sched #(
   parameter int FRAME_PIXELS = 76800,
   parameter int ADDR_W = 17
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              frame_start_in,
   input  logic              frame_end_in,
   input  logic              wr_valid_in,
   input  logic [ADDR_W-1:0] wr_addr_in,
   input  logic [7:0]        wr_pixel_in,
   input  logic              rd_req_in,
   output logic              bram_we_out,
   output logic [ADDR_W:0]   bram_addr_out,
   output logic [7:0]        bram_din_out,
   output logic              rd_bank_out,
   output logic              frame_ready_out,
   output logic              swap_out,
   output logic [7:0]        short_frames_out,
   output logic [7:0]        dropped_frames_out,
   output logic              addr_err_out
);
   typedef enum logic [1:0] {WAIT_SOF, CAPTURE, HOLD} state_t;
   localparam logic [ADDR_W-1:0] FP = ADDR_W'(FRAME_PIXELS);
   state_t state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic wr_bank, in_range, accept, short_inc, drop_inc, swap_nxt;
   assign wr_bank = ~rd_bank_out;
   assign in_range = wr_addr_in < FP;
   assign accept = state == CAPTURE && wr_valid_in && in_range;
   // completeness test on frame_end must include a pixel accepted in the same cycle
   assign cnt_inc = (accept && cnt != FP) ? cnt + 1'b1 : cnt;
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      short_inc = 1'b0;
      drop_inc = 1'b0;
      swap_nxt = 1'b0;
      case (state)
         WAIT_SOF: begin
            state_nxt = frame_start_in ? CAPTURE : WAIT_SOF;
            cnt_nxt = frame_start_in ? '0 : cnt;
         end
         CAPTURE: begin
            state_nxt = frame_end_in ? (cnt_inc == FP ? HOLD : WAIT_SOF) : CAPTURE;
            short_inc = frame_end_in ? cnt_inc != FP : frame_start_in;
            cnt_nxt = (frame_start_in && !frame_end_in) ? '0 : cnt_inc;
         end
         HOLD: begin
            drop_inc = frame_start_in;
            swap_nxt = rd_req_in;
            state_nxt = rd_req_in ? WAIT_SOF : HOLD;
         end
         default: state_nxt = WAIT_SOF;
      endcase
   end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= WAIT_SOF;
         cnt <= '0;
         rd_bank_out <= 1'b1;
         bram_we_out <= 1'b0;
         bram_addr_out <= '0;
         bram_din_out <= '0;
         frame_ready_out <= 1'b0;
         swap_out <= 1'b0;
         short_frames_out <= '0;
         dropped_frames_out <= '0;
         addr_err_out <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         rd_bank_out <= rd_bank_out ^ swap_nxt;
         bram_we_out <= accept;
         if (accept) begin
            bram_addr_out <= {wr_bank, wr_addr_in};
            bram_din_out <= wr_pixel_in;
         end
         frame_ready_out <= state_nxt == HOLD;
         swap_out <= swap_nxt;
         if (short_inc && short_frames_out != 8'hff) short_frames_out <= short_frames_out + 8'd1;
         if (drop_inc && dropped_frames_out != 8'hff) dropped_frames_out <= dropped_frames_out + 8'd1;
         addr_err_out <= addr_err_out | (wr_valid_in && !in_range);
      end
   end
endmodule

// File: tb/tb_frame_buffer_sched.sv
// tb_frame_buffer_sched: directed vector bench for frame_buffer_sched with a reduced frame size
module tb_frame_buffer_sched;
   localparam int FP = 64;
   localparam int AW = 17;
   localparam int B1 = 1 << AW;
   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic frame_start_in = 1'b0;
   logic frame_end_in = 1'b0;
   logic wr_valid_in = 1'b0;
   logic [AW-1:0] wr_addr_in = '0;
   logic [7:0] wr_pixel_in = '0;
   logic rd_req_in = 1'b0;
   logic bram_we_out;
   logic [AW:0] bram_addr_out;
   logic [7:0] bram_din_out;
   logic rd_bank_out;
   logic frame_ready_out;
   logic swap_out;
   logic [7:0] short_frames_out;
   logic [7:0] dropped_frames_out;
   logic addr_err_out;
   int checks = 0;
   int errors = 0;

   frame_buffer_sched #(.FRAME_PIXELS(FP), .ADDR_W(AW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
      .wr_valid_in(wr_valid_in), .wr_addr_in(wr_addr_in), .wr_pixel_in(wr_pixel_in), .rd_req_in(rd_req_in),
      .bram_we_out(bram_we_out), .bram_addr_out(bram_addr_out), .bram_din_out(bram_din_out),
      .rd_bank_out(rd_bank_out), .frame_ready_out(frame_ready_out), .swap_out(swap_out),
      .short_frames_out(short_frames_out), .dropped_frames_out(dropped_frames_out), .addr_err_out(addr_err_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic fs, fe, wv;
      logic [AW-1:0] a;
      logic [7:0] p;
      logic rr;
      logic we;
      logic [AW:0] ad;
      logic [7:0] d;
      logic rdy, sw;
      logic [7:0] sh, dr;
      logic err, rb;
   } vec_t;
   vec_t v[15];

   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", n, act, exp);
      end
   endtask

   task automatic step(input logic fs, input logic fe, input logic wv, input logic [AW-1:0] a,
                       input logic [7:0] p, input logic rr);
      frame_start_in = fs;
      frame_end_in = fe;
      wr_valid_in = wv;
      wr_addr_in = a;
      wr_pixel_in = p;
      rd_req_in = rr;
      @(posedge clk_in);
      #1;
      checks++;
      if (bram_we_out && bram_addr_out[AW] == rd_bank_out) begin
         errors++;
         $display("FAIL bank_conflict actual addr %0h rd_bank %0b", bram_addr_out, rd_bank_out);
      end
   endtask

   initial begin
      v[0]  = '{0,0,0,0,0,1,     0,0,0,0,0,0,0,0,1};
      v[1]  = '{0,0,1,5,8'h11,0, 0,0,0,0,0,0,0,0,1};
      v[2]  = '{1,0,0,0,0,0,     0,0,0,0,0,0,0,0,1};
      v[3]  = '{0,0,1,3,8'hAA,0, 1,3,8'hAA,0,0,0,0,0,1};
      v[4]  = '{0,0,1,7,8'h55,1, 1,7,8'h55,0,0,0,0,0,1};
      v[5]  = '{0,0,0,0,0,0,     0,0,0,0,0,0,0,0,1};
      v[6]  = '{1,0,0,0,0,0,     0,0,0,0,0,1,0,0,1};
      v[7]  = '{0,0,1,1,8'h22,0, 1,1,8'h22,0,0,1,0,0,1};
      v[8]  = '{0,1,0,0,0,0,     0,0,0,0,0,2,0,0,1};
      v[9]  = '{0,0,1,2,8'h03,0, 0,0,0,0,0,2,0,0,1};
      v[10] = '{1,0,0,0,0,0,     0,0,0,0,0,2,0,0,1};
      v[11] = '{0,0,1,FP,8'h77,0,0,0,0,0,0,2,0,1,1};
      v[12] = '{0,0,1,9,8'h99,0, 1,9,8'h99,0,0,2,0,1,1};
      v[13] = '{1,1,0,0,0,0,     0,0,0,0,0,3,0,1,1};
      v[14] = '{0,0,1,4,8'h44,0, 0,0,0,0,0,3,0,1,1};

      step(0,0,0,0,0,0);
      step(0,0,0,0,0,0);
      chk("rst_we", int'(bram_we_out), 0);
      chk("rst_addr", int'(bram_addr_out), 0);
      chk("rst_din", int'(bram_din_out), 0);
      chk("rst_rd_bank", int'(rd_bank_out), 1);
      chk("rst_ready", int'(frame_ready_out), 0);
      chk("rst_swap", int'(swap_out), 0);
      chk("rst_short", int'(short_frames_out), 0);
      chk("rst_drop", int'(dropped_frames_out), 0);
      chk("rst_err", int'(addr_err_out), 0);
      rst_in = 1'b0;

      for (int i = 0; i < 15; i++) begin
         step(v[i].fs, v[i].fe, v[i].wv, v[i].a, v[i].p, v[i].rr);
         chk($sformatf("v%0d_we", i), int'(bram_we_out), int'(v[i].we));
         if (v[i].we) begin
            chk($sformatf("v%0d_addr", i), int'(bram_addr_out), int'(v[i].ad));
            chk($sformatf("v%0d_din", i), int'(bram_din_out), int'(v[i].d));
         end
         chk($sformatf("v%0d_ready", i), int'(frame_ready_out), int'(v[i].rdy));
         chk($sformatf("v%0d_swap", i), int'(swap_out), int'(v[i].sw));
         chk($sformatf("v%0d_short", i), int'(short_frames_out), int'(v[i].sh));
         chk($sformatf("v%0d_drop", i), int'(dropped_frames_out), int'(v[i].dr));
         chk($sformatf("v%0d_err", i), int'(addr_err_out), int'(v[i].err));
         chk($sformatf("v%0d_rd_bank", i), int'(rd_bank_out), int'(v[i].rb));
      end

      rst_in = 1'b1;
      step(0,0,0,0,0,0);
      rst_in = 1'b0;
      chk("rst2_err", int'(addr_err_out), 0);
      chk("rst2_short", int'(short_frames_out), 0);

      // full frame into bank 0, then hold and drop 300 starts
      step(1,0,0,0,0,0);
      for (int i = 0; i < FP; i++) begin
         step(0,0,1,AW'(i),8'(i) ^ 8'h5A,0);
         chk($sformatf("f0_we%0d", i), int'(bram_we_out), 1);
         chk($sformatf("f0_addr%0d", i), int'(bram_addr_out), i);
         chk($sformatf("f0_din%0d", i), int'(bram_din_out), int'(8'(i) ^ 8'h5A));
      end
      step(0,1,0,0,0,0);
      chk("f0_ready", int'(frame_ready_out), 1);
      chk("f0_short", int'(short_frames_out), 0);
      chk("f0_rd_bank", int'(rd_bank_out), 1);
      for (int k = 0; k < 300; k++) begin
         step(1,0,1,AW'(k % FP),8'(k),0);
         chk($sformatf("hold_we%0d", k), int'(bram_we_out), 0);
      end
      chk("hold_drop_sat", int'(dropped_frames_out), 255);
      chk("hold_ready", int'(frame_ready_out), 1);
      step(0,0,0,0,0,1);
      chk("swap1_swap", int'(swap_out), 1);
      chk("swap1_rd_bank", int'(rd_bank_out), 0);
      chk("swap1_ready", int'(frame_ready_out), 0);
      step(0,0,0,0,0,0);
      chk("swap1_pulse_end", int'(swap_out), 0);

      // second frame into bank 1; final pixel, end and read request coincide
      step(1,0,0,0,0,0);
      for (int i = 0; i < FP - 1; i++) begin
         step(0,0,1,AW'(i),8'(i),0);
         chk($sformatf("f1_addr%0d", i), int'(bram_addr_out), B1 | i);
      end
      step(0,1,1,AW'(FP - 1),8'hC3,1);
      chk("last_we", int'(bram_we_out), 1);
      chk("last_addr", int'(bram_addr_out), B1 | (FP - 1));
      chk("last_din", int'(bram_din_out), 'hC3);
      chk("last_ready", int'(frame_ready_out), 1);
      chk("last_swap", int'(swap_out), 0);
      chk("last_rd_bank", int'(rd_bank_out), 0);
      chk("last_short", int'(short_frames_out), 0);
      step(0,0,0,0,0,1);
      chk("swap2_swap", int'(swap_out), 1);
      chk("swap2_rd_bank", int'(rd_bank_out), 1);
      chk("swap2_ready", int'(frame_ready_out), 0);
      step(1,0,0,0,0,0);
      step(0,0,1,10,8'h0F,0);
      chk("f2_we", int'(bram_we_out), 1);
      chk("f2_addr", int'(bram_addr_out), 10);

      // reset while a write is presented mid-capture
      rst_in = 1'b1;
      step(0,0,1,11,8'h05,0);
      rst_in = 1'b0;
      chk("midrst_we", int'(bram_we_out), 0);
      chk("midrst_rd_bank", int'(rd_bank_out), 1);
      chk("midrst_short", int'(short_frames_out), 0);
      chk("midrst_drop", int'(dropped_frames_out), 0);
      step(0,0,1,12,8'h06,0);
      chk("midrst_wait_we", int'(bram_we_out), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/frame_buffer_sched.md
FRAME_BUFFER_SCHED -- requirements
Module: frame_buffer_sched

Interface
REQ-001 Parameter FRAME_PIXELS, default 76800, SHALL be the pixels per complete frame (320x240 rotated image).
REQ-002 Parameter ADDR_W, default 17, SHALL be the per-bank pixel address width.
REQ-003 clk_in  input  1  SHALL be the 65 MHz system clock; all logic is on its rising edge.
REQ-004 rst_in  input  1  SHALL be a synchronous, active-high reset.
REQ-005 frame_start_in  input  1  SHALL be a one-cycle start-of-frame pulse from the capture path.
REQ-006 frame_end_in  input  1  SHALL be a one-cycle end-of-frame pulse from the capture path.
REQ-007 wr_valid_in  input  1  SHALL qualify wr_addr_in and wr_pixel_in.
REQ-008 wr_addr_in  input  ADDR_W  SHALL be the rotated pixel address.
REQ-009 wr_pixel_in  input  8  SHALL be the pixel value.
REQ-010 rd_req_in  input  1  SHALL be a one-cycle display vsync pulse requesting a new frame.
REQ-011 bram_we_out  output  1  SHALL be the frame-buffer write enable.
REQ-012 bram_addr_out  output  ADDR_W+1  SHALL be {write bank, pixel address}.
REQ-013 bram_din_out  output  8  SHALL be the write data.
REQ-014 rd_bank_out  output  1  SHALL select the bank the display reads.
REQ-015 frame_ready_out  output  1  SHALL be high while a complete, unswapped frame is held.
REQ-016 swap_out  output  1  SHALL pulse one cycle when banks swap.
REQ-017 short_frames_out  output  8  SHALL count incomplete frames, saturating at 255.
REQ-018 dropped_frames_out  output  8  SHALL count frames discarded in HOLD, saturating at 255.
REQ-019 addr_err_out  output  1  SHALL be a sticky flag set when wr_addr_in >= FRAME_PIXELS with wr_valid_in high.

Function
REQ-020 The block SHALL implement states WAIT_SOF, CAPTURE, HOLD and internal wr_bank, always equal to ~rd_bank_out.
REQ-021 WAIT_SOF: writes suppressed; frame_start_in -> CAPTURE with pixel count cleared to 0.
REQ-022 CAPTURE: each wr_valid_in with in-range address SHALL produce, one cycle later, bram_we_out=1, bram_addr_out={wr_bank,wr_addr_in}, bram_din_out=wr_pixel_in.
REQ-023 Out-of-range address SHALL produce bram_we_out=0, no count increment, and set addr_err_out.
REQ-024 The 17-bit pixel count SHALL increment per accepted write and saturate at FRAME_PIXELS.
REQ-025 frame_end_in in CAPTURE: count (including a same-cycle accepted pixel) == FRAME_PIXELS -> HOLD, frame_ready_out=1 next cycle; otherwise -> WAIT_SOF, short_frames_out+1.
REQ-026 frame_start_in in CAPTURE without frame_end_in: short_frames_out+1, count cleared, remain CAPTURE.
REQ-027 frame_start_in and frame_end_in together in CAPTURE: frame_end_in SHALL take priority; frame_start_in ignored.
REQ-028 HOLD: all writes suppressed; each frame_start_in increments dropped_frames_out.
REQ-029 rd_req_in in HOLD SHALL toggle rd_bank_out and wr_bank, clear frame_ready_out, pulse swap_out, and go to WAIT_SOF, all visible next cycle.
REQ-030 rd_req_in in WAIT_SOF or CAPTURE SHALL have no effect; a same-cycle frame_end_in/rd_req_in in CAPTURE SHALL enter HOLD without swapping.
REQ-031 bram_we_out SHALL never be high with bram_addr_out MSB equal to rd_bank_out.

Reset
REQ-032 On rst_in: state WAIT_SOF, rd_bank_out=1, wr_bank=0, pixel count 0, bram_we_out=0, bram_addr_out=0, bram_din_out=0, frame_ready_out=0, swap_out=0, both counters 0, addr_err_out=0.
REQ-033 rst_in mid-CAPTURE or mid-HOLD SHALL discard the frame in progress with no counter increment, and the next cycle SHALL have bram_we_out=0.

Verification
REQ-034 Reset, start, 76800 valid writes addr 0..76799, end -> 76800 writes to bank 0 (bram_addr_out MSB=0), HOLD, frame_ready_out=1.
REQ-035 From HOLD, rd_req_in -> next cycle swap_out=1, rd_bank_out=0, frame_ready_out=0; next frame writes carry MSB=1.
REQ-036 Start, 100 writes, end -> short_frames_out=1, state WAIT_SOF, frame_ready_out=0.
REQ-037 In HOLD, 300 frame_start_in pulses with writes -> bram_we_out stays 0, dropped_frames_out=255.
REQ-038 wr_addr_in=76800 with wr_valid_in in CAPTURE -> bram_we_out=0, addr_err_out=1 until reset.
REQ-039 Final pixel, frame_end_in and rd_req_in all in one cycle -> write occurs, HOLD entered, no swap; next rd_req_in swaps.
